// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush, saturating stall counter and optional skid buffer (PIPE_STAGE_SKID_EN)
module pipe_stage_reg #(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_count
);
  logic main_v, skid_v;
  logic [WIDTH-1:0] main_d;
  assign out_valid = main_v;
  assign out_data = main_v ? main_d : BUBBLE;
  always_ff @(posedge clk)
    if (reset) stall_count <= '0;
    else if (main_v && !out_ready && !(&stall_count)) stall_count <= stall_count + 1'b1;
`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_d;
  assign in_ready = ~skid_v;
  always_ff @(posedge clk)
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= BUBBLE;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (out_ready) begin
        main_d <= skid_d;
        skid_v <= 1'b0;
      end
    end else if (main_v && !out_ready) begin
      if (in_valid) begin
        skid_d <= in_data;
        skid_v <= 1'b1;
      end
    end else begin
      main_v <= in_valid;
      if (in_valid) main_d <= in_data;
    end
`else
  assign skid_v = 1'b0;
  assign in_ready = ~skid_v & (~main_v | out_ready);
  always_ff @(posedge clk)
    if (reset) begin
      main_v <= 1'b0;
      main_d <= BUBBLE;
    end else if (flush) main_v <= 1'b0;
    else if (in_ready) begin
      main_v <= in_valid;
      if (in_valid) main_d <= in_data;
    end
`endif
endmodule
